// File: rtl/lsu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : lsu_pkg                                                      |
// | Purpose  : Shared definitions for the load/store memory master:         |
// |            memop encodings, FSM state encoding, byte-enable and         |
// |            store-lane replication helpers.                              |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
package lsu_pkg;

  // RISC-V funct3 load/store width encodings
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // FSM state encoding
  localparam int         ST_W    = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RESP = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Byte enables for a legal access; only the width bits of memop matter.
  function automatic logic [3:0] lsu_byte_en(input logic [2:0] memop,
                                             input logic [1:0] addr_lo);
    case (memop[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it could occupy,
  // so the RAM picks the correct bytes purely from the byte enables.
  function automatic logic [31:0] lsu_wdata_rep(input logic [2:0]  memop,
                                                input logic [31:0] wdata);
    case (memop[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : lsu_load_align                                               |
// | Purpose  : Combinational load-data lane select with sign/zero extension.|
// | Ports    : i_memop   [2:0]  funct3 memop (bit 2 = unsigned)             |
// |            i_addr_lo [1:0]  byte offset within the word                 |
// |            i_rdata   [31:0] raw memory word                             |
// |            o_data    [31:0] right-justified, extended load result       |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module lsu_load_align (
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_memop[1:0])
      2'b00:   o_data = i_memop[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   o_data = i_memop[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : lsu_mem_master                                               |
// | Purpose  : Load/store initiator between CPU execute stage and data RAM. |
// |            One byte-addressed access per request, issued to memory as a |
// |            word-addressed, byte-enabled req/gnt/rvalid transaction.     |
// | Ports    : CPU side : i_cpu_valid/o_cpu_ready handshake, i_cpu_we,      |
// |                       i_cpu_memop, i_cpu_addr, i_cpu_wdata;             |
// |                       o_cpu_rvalid pulse with o_cpu_rdata, o_cpu_err    |
// |            MEM side : o_mem_req/i_mem_gnt, o_mem_we, o_mem_addr,        |
// |                       o_mem_be, o_mem_wdata; i_mem_rvalid, i_mem_rdata  |
// | Config   : LSU_TIMEOUT_EN - abort REQ/RESP after TIMEOUT cycles         |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cpu_valid,
  output logic          o_cpu_ready,
  input  logic          i_cpu_we,
  input  logic [2:0]    i_cpu_memop,
  input  logic [31:0]   i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  output logic          o_cpu_rvalid,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_err,
  output logic          o_mem_req,
  input  logic          i_mem_gnt,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_mem_be,
  output logic [31:0]   o_mem_wdata,
  input  logic          i_mem_rvalid,
  input  logic [31:0]   i_mem_rdata
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;
  logic            w_accept;
  logic            w_err;
  logic            w_tmo;
  logic [31:0]     w_load_data;

  logic            r_we;
  logic [2:0]      r_memop;
  logic [1:0]      r_addr_lo;
  logic [AW-1:0]   r_mem_addr;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  assign w_accept = (r_state == ST_IDLE) && i_cpu_valid;

  // Illegal encodings, unsigned stores, misalignment, or outside the RAM.
  assign w_err = (i_cpu_memop == 3'b011) || (i_cpu_memop == 3'b110) ||
                 (i_cpu_memop == 3'b111) ||
                 (i_cpu_we && i_cpu_memop[2]) ||
                 ((i_cpu_memop[1:0] == 2'b01) && i_cpu_addr[0]) ||
                 ((i_cpu_memop[1:0] == 2'b10) && (i_cpu_addr[1:0] != 2'b00)) ||
                 (i_cpu_addr[31:AW+2] != '0);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;

  // r_cnt holds (cycles already spent in this wait state); on the
  // TIMEOUT-th cycle without a memory event the FSM aborts.
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == ST_REQ) || (r_state == ST_RESP)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a memory event always wins over a same-cycle timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_cpu_valid)       w_next = w_err ? ST_ERR : ST_REQ;
      ST_REQ:  if (i_mem_gnt)         w_next = r_we ? ST_DONE : ST_RESP;
               else if (w_tmo)        w_next = ST_ERR;
      ST_RESP: if (i_mem_rvalid)      w_next = ST_DONE;
               else if (w_tmo)        w_next = ST_ERR;
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only, so an async reset clears them at once.
  always_comb begin
    o_cpu_ready  = (r_state == ST_IDLE);
    o_mem_req    = (r_state == ST_REQ);
    o_cpu_rvalid = (r_state == ST_DONE) || (r_state == ST_ERR);
    o_cpu_err    = (r_state == ST_ERR);
    o_cpu_rdata  = (r_state == ST_DONE) ? r_rdata : 32'b0;
  end

  // Request fields latched at acceptance and held stable until grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_memop    <= 3'b0;
      r_addr_lo  <= 2'b0;
      r_mem_addr <= '0;
      r_be       <= 4'b0;
      r_wdata    <= 32'b0;
      r_rdata    <= 32'b0;
    end else if (w_accept) begin
      r_we       <= i_cpu_we;
      r_memop    <= i_cpu_memop;
      r_addr_lo  <= i_cpu_addr[1:0];
      r_mem_addr <= i_cpu_addr[AW+1:2];
      r_be       <= lsu_byte_en(i_cpu_memop, i_cpu_addr[1:0]);
      r_wdata    <= lsu_wdata_rep(i_cpu_memop, i_cpu_wdata);
      r_rdata    <= 32'b0;
    end else if ((r_state == ST_RESP) && i_mem_rvalid) begin
      r_rdata    <= w_load_data;
    end
  end

  lsu_load_align u_align (
    .i_memop   (r_memop),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (i_mem_rdata),
    .o_data    (w_load_data)
  );

  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_be;
  assign o_mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_lsu_mem_master                                            |
// | Purpose  : Scoreboard bench for lsu_mem_master: byte-level reference    |
// |            memory model, randomized memory latencies, reset and (with   |
// |            LSU_TIMEOUT_EN) timeout scenarios.                           |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int AW  = 10;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cpu_valid, i_cpu_we, i_mem_gnt, i_mem_rvalid;
  logic [2:0]    i_cpu_memop;
  logic [31:0]   i_cpu_addr, i_cpu_wdata, i_mem_rdata;
  logic          o_cpu_ready, o_cpu_rvalid, o_cpu_err, o_mem_req, o_mem_we;
  logic [31:0]   o_cpu_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_be;

  lsu_mem_master #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_valid(i_cpu_valid), .o_cpu_ready(o_cpu_ready), .i_cpu_we(i_cpu_we),
    .i_cpu_memop(i_cpu_memop), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata), .o_cpu_err(o_cpu_err),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] rdata; logic err; int unsigned cyc; } rsp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [3:0] be; logic [31:0] wdata;
                   int gd; int rd; int mode; } mex_t;
  rsp_t sbq[$];
  mex_t mq[$];

  logic [7:0]  ref_mem  [0:4095];
  logic [31:0] resp_mem [0:1023];
  bit granted, hold_done;
  int wait_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // mode 0: normal memory, 1: withhold grant, 2: grant then withhold rvalid
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input int gd, input int rd,
                       input int mode, input bit want_rsp);
    int n, guard;
    logic err;
    logic [31:0] v;
    logic [3:0] bm;
    rsp_t r;
    mex_t m;
    guard = 0;
    @(negedge clk);
    while (!o_cpu_ready && guard < 200) begin @(negedge clk); guard++; end
    chk("cpu_ready_wait", 32'(o_cpu_ready), 32'd1);
    if (!o_cpu_ready) return;
    n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    err = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[2]) ||
          (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00) || (addr >= (32'd4 << AW));
    v = 32'b0;
    r.err = 1'b0;
    r.rdata = 32'b0;
    if (err) begin
      r.err = 1'b1;
      r.cyc = cyc + 1;
    end else begin
      bm = 4'((1 << n) - 1);
      m.we = we; m.addr = addr[AW+1:2]; m.be = bm << addr[1:0];
      m.wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
      m.gd = gd; m.rd = rd; m.mode = mode;
      mq.push_back(m);
      if (we) begin
        if (mode == 0) for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
        r.cyc = cyc + 2 + gd;
      end else begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[addr + i];
        if (!op[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!op[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        r.rdata = v;
        r.cyc = cyc + 3 + gd + rd;
      end
      if (mode == 1) begin
        r.rdata = 32'b0; r.err = 1'b1; r.cyc = cyc + 1 + TMO;
      end
    end
    if (want_rsp) sbq.push_back(r);
    i_cpu_valid = 1'b1; i_cpu_we = we; i_cpu_memop = op; i_cpu_addr = addr; i_cpu_wdata = wd;
    @(negedge clk);
    i_cpu_valid = 1'b0; i_cpu_we = 1'($urandom); i_cpu_memop = 3'($urandom);
    i_cpu_addr = $urandom; i_cpu_wdata = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || mq.size() != 0) && g < 200) begin @(negedge clk); g++; end
    chk("drain_sbq", 32'(sbq.size()), 32'd0);
    chk("drain_memq", 32'(mq.size()), 32'd0);
  endtask

  // Monitor: pops one expectation per completion pulse.
  always @(negedge clk) begin
    if (rst_n && o_cpu_rvalid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rvalid", 32'(o_cpu_rvalid), 32'd0);
      end else begin
        rsp_t e;
        e = sbq.pop_front();
        chk("cpu_rdata", o_cpu_rdata, e.rdata);
        chk("cpu_err", 32'(o_cpu_err), 32'(e.err));
        chk("rvalid_cycle", cyc, e.cyc);
        chk("ready_low_at_rvalid", 32'(o_cpu_ready), 32'd0);
      end
    end
  end

  // Memory responder: word RAM written through the DUT's byte enables.
  initial begin
    mex_t m;
    int c;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'b0;
    forever begin
      @(negedge clk);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      if (rst_n && o_mem_req) begin
        if (mq.size() == 0) begin
          chk("unexpected_mem_req", 32'(o_mem_req), 32'd0);
        end else begin
          m = mq.pop_front();
          if (m.mode == 1) begin
            c = 0;
            while (o_mem_req && c < 1000) begin c++; @(negedge clk); end
            wait_cnt = c;
          end else begin
            for (int g = 0; g <= m.gd; g++) begin
              if (g > 0) @(negedge clk);
              chk("mem_req_held", 32'(o_mem_req), 32'd1);
              chk("mem_we", 32'(o_mem_we), 32'(m.we));
              chk("mem_addr", 32'(o_mem_addr), 32'(m.addr));
              chk("mem_be", 32'(o_mem_be), 32'(m.be));
              if (m.we) chk("mem_wdata", o_mem_wdata, m.wdata);
            end
            i_mem_gnt = 1'b1;
            if (m.we)
              for (int b = 0; b < 4; b++)
                if (o_mem_be[b]) resp_mem[o_mem_addr][8*b +: 8] = o_mem_wdata[8*b +: 8];
            @(negedge clk);
            i_mem_gnt = 1'b0;
            chk("mem_req_after_gnt", 32'(o_mem_req), 32'd0);
            if (!m.we && m.mode == 2) begin
              granted = 1'b1;
              c = 0;
              while (!hold_done && c < 200) begin @(negedge clk); c++; end
              i_mem_rvalid = 1'b1; i_mem_rdata = $urandom;
              @(negedge clk);
              i_mem_rvalid = 1'b0;
            end else if (!m.we) begin
              repeat (m.rd) @(negedge clk);
              i_mem_rvalid = 1'b1; i_mem_rdata = resp_mem[m.addr];
              @(negedge clk);
              i_mem_rvalid = 1'b0;
            end
          end
        end
      end else begin
        // Stray handshakes while no request is pending must be ignored.
        i_mem_gnt = ($urandom_range(0, 3) == 0);
        i_mem_rvalid = ($urandom_range(0, 3) == 0);
        i_mem_rdata = $urandom;
      end
    end
  end

  initial begin
    logic [2:0] op;
    logic we;
    logic [31:0] addr;
    int g;
    i_cpu_valid = 1'b0; i_cpu_we = 1'b0; i_cpu_memop = 3'b0; i_cpu_addr = 32'b0; i_cpu_wdata = 32'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) resp_mem[i] = 32'h0;
    granted = 1'b0; hold_done = 1'b0; wait_cnt = 0;

    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 32'(o_cpu_ready), 32'd1);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_cpu_rvalid", 32'(o_cpu_rvalid), 32'd0);
    chk("rst_cpu_err", 32'(o_cpu_err), 32'd0);
    chk("rst_cpu_rdata", o_cpu_rdata, 32'd0);
    chk("rst_mem_outs", {o_mem_wdata[27:0] | 28'(o_mem_addr), o_mem_be}, 32'd0);
    chk("rst_mem_we", 32'(o_mem_we), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    issue(1'b1, MEMOP_W,  32'h10, 32'hDEADBEEF, 0, 0, 0, 1'b1);
    issue(1'b1, MEMOP_B,  32'h13, 32'h000000A5, 3, 0, 0, 1'b1);
    issue(1'b0, MEMOP_W,  32'h10, 32'h0,        1, 1, 0, 1'b1);
    issue(1'b1, MEMOP_W,  32'h10, 32'h123480FF, 0, 0, 0, 1'b1);
    issue(1'b0, MEMOP_B,  32'h11, 32'h0,        0, 1, 0, 1'b1);
    issue(1'b0, MEMOP_BU, 32'h11, 32'h0,        0, 1, 0, 1'b1);
    issue(1'b1, MEMOP_W,  32'h10, 32'h80010000, 0, 0, 0, 1'b1);
    issue(1'b0, MEMOP_H,  32'h12, 32'h0,        2, 0, 0, 1'b1);
    issue(1'b0, MEMOP_HU, 32'h12, 32'h0,        0, 2, 0, 1'b1);
    issue(1'b1, MEMOP_H,  32'h16, 32'h0000BEEF, 1, 0, 0, 1'b1);
    issue(1'b0, MEMOP_W,  32'h02, 32'h0,        0, 0, 0, 1'b1);
    issue(1'b0, 3'b011,   32'h10, 32'h0,        0, 0, 0, 1'b1);
    issue(1'b1, MEMOP_BU, 32'h10, 32'h0,        0, 0, 0, 1'b1);
    issue(1'b0, MEMOP_W,  32'h1000, 32'h0,      0, 0, 0, 1'b1);
    issue(1'b0, MEMOP_HU, 32'h0FFF, 32'h0,      0, 0, 0, 1'b1);
    drain();

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      op = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      if (we && $urandom_range(0, 3) != 0) op = {1'b0, op[1:0]};
      if ($urandom_range(0, 3) != 0 && op[1:0] == 2'b11) op = MEMOP_W;
      g = $urandom_range(0, 15);
      if (g == 0)      addr = $urandom;
      else if (g == 1) addr = 32'($urandom_range(0, 4095));
      else begin
        addr = 32'($urandom_range(0, 31)) * 4 + ((g == 2) ? 32'($urandom_range(0, 1023)) * 4 : 32'd0);
        addr = addr & 32'hFFF;
        if (op[1:0] == 2'b00) addr = addr + 32'($urandom_range(0, 3));
        else if (op[1:0] == 2'b01) addr = addr + 32'($urandom_range(0, 1)) * 2;
      end
      issue(we, op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b1);
    end
    drain();

    // Reset while waiting for read data: response abandoned, late rvalid ignored
    issue(1'b0, MEMOP_W, 32'h20, 32'h0, 0, 0, 2, 1'b0);
    g = 0;
    while (!granted && g < 50) begin @(negedge clk); g++; end
    chk("granted_before_reset", 32'(granted), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_resp_rvalid", 32'(o_cpu_rvalid), 32'd0);
    chk("rst_resp_ready", 32'(o_cpu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hold_done = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 32'(o_cpu_ready), 32'd1);
    chk("post_rst_rvalid", 32'(o_cpu_rvalid), 32'd0);

    // Reset while a request is outstanding: mem_req drops immediately
    issue(1'b0, MEMOP_W, 32'h24, 32'h0, 0, 0, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("req_before_reset", 32'(o_mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_mem_req", 32'(o_mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drain();

`ifdef LSU_TIMEOUT_EN
    issue(1'b0, MEMOP_W, 32'h28, 32'h0, 0, 0, 1, 1'b1);
    drain();
    chk("timeout_req_cycles", 32'(wait_cnt), 32'(TMO));
`endif

    // Memory contents survive the LSU reset; keep going after it
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 2));
      we = 1'($urandom);
      addr = 32'($urandom_range(0, 31)) * 4;
      if (op == MEMOP_B) addr = addr + 32'($urandom_range(0, 3));
      if (op == MEMOP_H) addr = addr + 32'($urandom_range(0, 1)) * 2;
      issue(we, op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
